// File: rtl/layer_field_gen.sv
// layer_field_gen: scrolling block-layer field for SkyHop with pixel scroll animation,
// LFSR-generated top layers and a one-deep jump queue.
module layer_field_gen #(
  parameter int          N_LAYERS    = 5,
  parameter int          N_COLS      = 7,
  parameter int          LAYER_SPACE = 150,
  parameter int          SCROLL_STEP = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       module_en,
  input  logic                       one_ms_tick,
  input  logic                       jump_left,
  input  logic                       jump_right,
  output logic [N_LAYERS*N_COLS-1:0] layer_map,
  output logic [N_LAYERS*N_COLS-1:0] block_type,
  output logic [9:0]                 scroll_offset,
  output logic                       busy,
  output logic [15:0]                layer_count
);
  localparam int W = N_LAYERS * N_COLS;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] EVEN16 = 16'h5555;
  localparam logic [15:0] ODD16 = 16'hAAAA;
  localparam logic [N_COLS-1:0] EVEN = EVEN16[N_COLS-1:0];
  localparam logic [N_COLS-1:0] ODD = ODD16[N_COLS-1:0];
  localparam logic [N_COLS-1:0] EVEN_LOW = {{(N_COLS-1){1'b0}}, 1'b1};
  localparam logic [N_COLS-1:0] ODD_LOW = {{(N_COLS-2){1'b0}}, 2'b10};
  localparam logic TOP_ODD = (N_LAYERS % 2) == 0;
  function automatic logic [W-1:0] init_map();
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < N_LAYERS; i++) m[i*N_COLS +: N_COLS] = (i % 2 == 1) ? ODD : EVEN;
    return m;
  endfunction
  localparam logic [W-1:0] INIT_MAP = init_map();
  typedef enum logic [1:0] {IDLE, SCROLL, COMMIT} state_t;
  state_t             state_q, state_n;
  logic [W-1:0]       map_q, map_n, type_q, type_n;
  logic [9:0]         off_q, off_n;
  logic [15:0]        count_q, count_n, lfsr_q;
  logic               pending_q, pending_n, top_odd_q, top_n, busy_q, jump;
  logic [10:0]        sum;
  logic [N_COLS-1:0]  mask, cand, new_map, new_type;
  always_comb begin
    jump = jump_left | jump_right;
    sum = {1'b0, off_q} + 11'(SCROLL_STEP);
    // the new top layer always takes the parity opposite to the current top
    mask = top_odd_q ? EVEN : ODD;
    cand = lfsr_q[N_COLS-1:0] & mask;
    new_map = (cand == '0) ? (top_odd_q ? EVEN_LOW : ODD_LOW) : cand;
    new_type = lfsr_q[8 +: N_COLS] & new_map;
    state_n = state_q;
    pending_n = pending_q;
    off_n = off_q;
    map_n = map_q;
    type_n = type_q;
    top_n = top_odd_q;
    count_n = count_q;
    case (state_q)
      IDLE: begin
        state_n = (jump || pending_q) ? SCROLL : IDLE;
        pending_n = 1'b0;
      end
      SCROLL: begin
        state_n = (one_ms_tick && sum >= 11'(LAYER_SPACE)) ? COMMIT : SCROLL;
        off_n = (one_ms_tick && sum < 11'(LAYER_SPACE)) ? sum[9:0] : off_q;
        pending_n = pending_q | jump;
      end
      COMMIT: begin
        state_n = pending_q ? SCROLL : IDLE;
        pending_n = !pending_q && jump;
        off_n = '0;
        map_n = {new_map, map_q[W-1:N_COLS]};
        type_n = {new_type, type_q[W-1:N_COLS]};
        top_n = !top_odd_q;
        count_n = (&count_q) ? count_q : count_q + 16'd1;
      end
      default: state_n = IDLE;
    endcase
    if (!module_en) begin
      state_n = IDLE;
      pending_n = 1'b0;
      off_n = '0;
      map_n = INIT_MAP;
      type_n = '0;
      top_n = TOP_ODD;
      count_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      off_q <= '0;
      map_q <= INIT_MAP;
      type_q <= '0;
      top_odd_q <= TOP_ODD;
      count_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pending_q <= pending_n;
      off_q <= off_n;
      map_q <= map_n;
      type_q <= type_n;
      top_odd_q <= top_n;
      count_q <= count_n;
      busy_q <= state_n != IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign layer_map = map_q;
  assign block_type = type_q;
  assign scroll_offset = off_q;
  assign busy = busy_q;
  assign layer_count = count_q;
endmodule

// File: tb/tb_layer_field_gen.sv
// tb_layer_field_gen: random stimulus against a queue-based field model, scoreboard-checked every cycle.
module tb_layer_field_gen;
  localparam int NL = 5, NC = 7, SPACE = 150, STEP = 3, W = NL * NC, NCYC = 30000;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, rst = 1, module_en = 1, one_ms_tick = 0, jump_left = 0, jump_right = 0;
  logic [W-1:0] layer_map, block_type;
  logic [9:0] scroll_offset;
  logic busy;
  logic [15:0] layer_count;
  int checks = 0, errors = 0, max_off = 0;
  typedef struct packed {
    logic [W-1:0] map;
    logic [W-1:0] typ;
    logic [9:0]   off;
    logic         busy;
    logic [15:0]  cnt;
  } exp_t;
  exp_t sb[$];
  int m_phase, m_ticks, m_cnt;
  bit m_pend, m_top_odd;
  logic [15:0] m_lfsr;
  logic [NC-1:0] m_lay[$], m_typ[$];

  layer_field_gen #(.N_LAYERS(NL), .N_COLS(NC), .LAYER_SPACE(SPACE), .SCROLL_STEP(STEP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .one_ms_tick(one_ms_tick),
    .jump_left(jump_left), .jump_right(jump_right), .layer_map(layer_map),
    .block_type(block_type), .scroll_offset(scroll_offset), .busy(busy), .layer_count(layer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NC-1:0] pattern(input int odd);
    logic [NC-1:0] p;
    for (int j = 0; j < NC; j++) p[j] = ((j % 2) == odd);
    return p;
  endfunction

  task automatic m_init();
    m_phase = 0; m_ticks = 0; m_pend = 0; m_cnt = 0;
    m_lay.delete(); m_typ.delete();
    for (int i = 0; i < NL; i++) begin
      m_lay.push_back(pattern(i % 2));
      m_typ.push_back('0);
    end
    m_top_odd = ((NL - 1) % 2) == 1;
  endtask

  task automatic m_step(input bit r, input bit en, input bit tk, input bit jp);
    logic [15:0] lf;
    logic [NC-1:0] mk, cand, nm;
    bit old;
    if (r) begin
      m_init();
      m_lfsr = SEED;
      return;
    end
    lf = m_lfsr;
    m_lfsr = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
    if (!en) begin
      m_init();
      return;
    end
    case (m_phase)
      0: if (jp || m_pend) begin m_phase = 1; m_pend = 0; m_ticks = 0; end
      1: begin
        if (tk) begin
          if ((m_ticks + 1) * STEP >= SPACE) m_phase = 2;
          else m_ticks++;
        end
        if (jp) m_pend = 1;
      end
      default: begin
        mk = pattern(m_top_odd ? 0 : 1);
        cand = lf[NC-1:0] & mk;
        nm = cand;
        if (cand == 0)
          for (int j = 0; j < NC; j++) if (mk[j] && nm == 0) nm[j] = 1'b1;
        void'(m_lay.pop_front()); m_lay.push_back(nm);
        void'(m_typ.pop_front()); m_typ.push_back(lf[8 +: NC] & nm);
        m_top_odd = !m_top_odd;
        m_ticks = 0;
        if (m_cnt < 65535) m_cnt++;
        old = m_pend;
        m_phase = old ? 1 : 0;
        m_pend = !old && jp;
      end
    endcase
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    for (int i = 0; i < NL; i++) begin
      e.map[i*NC +: NC] = m_lay[i];
      e.typ[i*NC +: NC] = m_typ[i];
    end
    e.off = 10'(m_ticks * STEP);
    e.busy = m_phase != 0;
    e.cnt = 16'(m_cnt);
    return e;
  endfunction

  initial begin
    int off_left, r, jdiv;
    off_left = 0;
    m_init();
    m_lfsr = SEED;
    for (int c = 0; c < NCYC; c++) begin
      rst = (c < 2) || (c >= 15000 && c < 15002);
      if (off_left > 0) begin
        module_en = 0;
        off_left--;
      end else begin
        module_en = 1;
        if (c > 2 && $urandom_range(0, 399) == 0) off_left = $urandom_range(1, 3);
      end
      jdiv = (c < 15000) ? 30 : 300;
      r = $urandom_range(0, jdiv - 1);
      jump_left = (c == 3) || r == 0 || r == 2;
      jump_right = r == 1 || r == 2;
      one_ms_tick = $urandom_range(0, 1);
      m_step(rst, module_en, one_ms_tick, jump_left | jump_right);
      sb.push_back(m_expect());
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    checks++;
    if (max_off != SPACE - STEP) begin
      errors++;
      $display("FAIL max_offset: got %0d, required %0d", max_off, SPACE - STEP);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #7;
    checks++;
    if (layer_map !== 35'b1010101_0101010_1010101_0101010_1010101 || block_type !== '0 ||
        busy !== 1'b0 || scroll_offset !== 10'd0 || layer_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: map=%b type=%h busy=%b off=%0d cnt=%0d, required init pattern and zeros",
               layer_map, block_type, busy, scroll_offset, layer_count);
    end
  end

  initial forever begin
    exp_t e, got;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {layer_map, block_type, scroll_offset, busy, layer_count};
      if (int'(scroll_offset) > max_off) max_off = int'(scroll_offset);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_state t=%0t: map=%h/%h type=%h/%h off=%0d/%0d busy=%0d/%0d cnt=%0d/%0d (got/required)",
                 $time, got.map, e.map, got.typ, e.typ, got.off, e.off, got.busy, e.busy, got.cnt, e.cnt);
      end
    end
  end
endmodule
